// File: rtl/cache_nway_wb.sv
// N-way set-associative write-back, write-allocate cache with tree pseudo-LRU replacement.
// Define CACHE_NWAY_PERF_CNT_EN to add saturating hit/miss/writeback counters.
module cache_nway_wb #(
    parameter int NUM_WAYS   = 4,
    parameter int NUM_SETS   = 8,
    parameter int LINE_BYTES = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [31:0]             mem_address,
    input  logic [31:0]             mem_wdata,
    input  logic [3:0]              mem_byte_enable,
    output logic                    mem_resp,
    output logic [31:0]             mem_rdata,
    input  logic                    pmem_resp,
    input  logic [8*LINE_BYTES-1:0] pmem_rdata,
    output logic [31:0]             pmem_address,
    output logic [8*LINE_BYTES-1:0] pmem_wdata,
    output logic                    pmem_read,
    output logic                    pmem_write
`ifdef CACHE_NWAY_PERF_CNT_EN
    ,
    output logic [31:0]             perf_hits,
    output logic [31:0]             perf_misses,
    output logic [31:0]             perf_writebacks
`endif
);

    localparam int OFF    = $clog2(LINE_BYTES);
    localparam int IDX    = $clog2(NUM_SETS);
    localparam int TAG_W  = 32 - OFF - IDX;
    localparam int WAY_W  = $clog2(NUM_WAYS);
    localparam int LINE_W = 8 * LINE_BYTES;
    localparam int WORDS  = LINE_BYTES / 4;
    localparam int WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, CHECK, WB, FILL} state_t;

    state_t state, state_next;

    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
    logic [NUM_WAYS-2:0] plru_q  [NUM_SETS];
    logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
    logic [LINE_W-1:0]   data_q  [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]    victim_q;

    logic [IDX-1:0]    req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [WSEL_W-1:0] word_sel;
    logic              unused_addr_lsbs;

    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic              has_invalid;
    logic [WAY_W-1:0]  invalid_way;
    logic [WAY_W-1:0]  victim_sel;
    logic              victim_dirty;
    logic [LINE_W-1:0] hit_line;
    logic [31:0]       hit_word;
    logic [31:0]       merged_word;
    logic [LINE_W-1:0] merged_line;

    assign req_idx          = mem_address[OFF+IDX-1:OFF];
    assign req_tag          = mem_address[31:OFF+IDX];
    assign unused_addr_lsbs = ^mem_address[1:0];

    if (WORDS > 1) begin : g_word_sel
        assign word_sel = mem_address[OFF-1:2];
    end else begin : g_single_word
        assign word_sel = '0;
    end

    // Level l of the tree decides way bit l (LSB at the root); each node bit names the side to evict next.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [NUM_WAYS-2:0] t);
        logic [WAY_W-1:0] node;
        logic [WAY_W-1:0] way;
        node = '0;
        way  = '0;
        for (int l = 0; l < WAY_W; l++) begin
            way[l] = t[node];
            node   = WAY_W'(2 * int'(node) + 1 + int'(t[node]));
        end
        return way;
    endfunction

    function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] t,
                                                      input logic [WAY_W-1:0]    way);
        logic [NUM_WAYS-2:0] r;
        logic [WAY_W-1:0]    node;
        r    = t;
        node = '0;
        for (int l = 0; l < WAY_W; l++) begin
            r[node] = ~way[l];
            node    = WAY_W'(2 * int'(node) + 1 + int'(way[l]));
        end
        return r;
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        hit         = 1'b0;
        hit_way     = '0;
        has_invalid = 1'b0;
        invalid_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        // Scan downward so the lowest-numbered invalid way wins.
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) begin
                has_invalid = 1'b1;
                invalid_way = WAY_W'(w);
            end
        end
        victim_sel   = has_invalid ? invalid_way : plru_victim(plru_q[req_idx]);
        victim_dirty = valid_q[req_idx][victim_sel] && dirty_q[req_idx][victim_sel];
    end

    always_comb begin
        hit_line = data_q[req_idx][hit_way];
        hit_word = hit_line[32*int'(word_sel) +: 32];
        for (int b = 0; b < 4; b++) begin
            merged_word[8*b +: 8] = mem_byte_enable[b] ? mem_wdata[8*b +: 8] : hit_word[8*b +: 8];
        end
        merged_line = hit_line;
        merged_line[32*int'(word_sel) +: 32] = merged_word;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            victim_q     <= '0;
            pmem_address <= '0;
        end else begin
            state <= state_next;
            if (state == CHECK && !hit) begin
                victim_q     <= victim_sel;
                pmem_address <= victim_dirty ? {tag_q[req_idx][victim_sel], req_idx, {OFF{1'b0}}}
                                             : {req_tag, req_idx, {OFF{1'b0}}};
            end else if (state == WB && pmem_resp) begin
                pmem_address <= {req_tag, req_idx, {OFF{1'b0}}};
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (mem_read || mem_write) state_next = CHECK;
            CHECK:   state_next = hit ? IDLE : (victim_dirty ? WB : FILL);
            WB:      if (pmem_resp) state_next = FILL;
            FILL:    if (pmem_resp) state_next = CHECK;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_resp   = (state == CHECK) && hit;
        mem_rdata  = mem_resp ? hit_word : 32'd0;
        pmem_read  = (state == FILL);
        pmem_write = (state == WB);
        pmem_wdata = data_q[req_idx][victim_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            if (state == CHECK && hit) begin
                plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_way);
                if (mem_write) dirty_q[req_idx][hit_way] <= 1'b1;
            end
            if (state == FILL && pmem_resp) begin
                valid_q[req_idx][victim_q] <= 1'b1;
                dirty_q[req_idx][victim_q] <= 1'b0;
            end
        end
    end

    // NOTE: tag and data arrays carry no reset; the valid bits alone make their contents meaningful.
    always_ff @(posedge clk) begin
        if (state == CHECK && hit && mem_write) begin
            data_q[req_idx][hit_way] <= merged_line;
        end
        if (state == FILL && pmem_resp) begin
            data_q[req_idx][victim_q] <= pmem_rdata;
            tag_q[req_idx][victim_q]  <= req_tag;
        end
    end

`ifdef CACHE_NWAY_PERF_CNT_EN
    logic refill_q;

    // The CHECK that follows a FILL is a guaranteed hit and is not classified again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refill_q        <= 1'b0;
            perf_hits       <= '0;
            perf_misses     <= '0;
            perf_writebacks <= '0;
        end else begin
            if (state == FILL && pmem_resp) refill_q <= 1'b1;
            else if (state == CHECK)        refill_q <= 1'b0;
            if (state == CHECK && !refill_q) begin
                if (hit && perf_hits != 32'hFFFF_FFFF)     perf_hits   <= perf_hits + 32'd1;
                if (!hit && perf_misses != 32'hFFFF_FFFF)  perf_misses <= perf_misses + 32'd1;
            end
            if (state == WB && pmem_resp && perf_writebacks != 32'hFFFF_FFFF) begin
                perf_writebacks <= perf_writebacks + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_nway_wb.sv
// Directed bench for cache_nway_wb with a fixed-latency line memory responder.
// Build with CACHE_NWAY_PERF_CNT_EN defined to also exercise the performance counters.
module tb_cache_nway_wb;

    localparam int LINE_W = 256;
    localparam int LAT    = 3;

    logic              clk;
    logic              rst_n;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_address;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_byte_enable;
    logic              mem_resp;
    logic [31:0]       mem_rdata;
    logic              pmem_resp;
    logic [LINE_W-1:0] pmem_rdata;
    logic [31:0]       pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic              pmem_read;
    logic              pmem_write;
`ifdef CACHE_NWAY_PERF_CNT_EN
    logic [31:0]       perf_hits;
    logic [31:0]       perf_misses;
    logic [31:0]       perf_writebacks;
`endif

    typedef struct {
        bit                wr;
        logic [31:0]       addr;
        logic [LINE_W-1:0] data;
    } xfer_t;

    xfer_t             log_q[$];
    logic [LINE_W-1:0] mem_store [logic [31:0]];
    int                checks;
    int                errors;

    cache_nway_wb dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .pmem_resp       (pmem_resp),
        .pmem_rdata      (pmem_rdata),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write)
`ifdef CACHE_NWAY_PERF_CNT_EN
        ,
        .perf_hits       (perf_hits),
        .perf_misses     (perf_misses),
        .perf_writebacks (perf_writebacks)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Untouched memory holds each word's own byte address, so expected read data is the address.
    function automatic logic [LINE_W-1:0] default_line(input logic [31:0] a);
        logic [LINE_W-1:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = a + 32'(4 * w);
        return l;
    endfunction

    function automatic logic [LINE_W-1:0] line_of(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return default_line(a);
    endfunction

    // Physical memory: answers LAT cycles after a request appears, checks exclusivity and stability.
    initial begin
        int                cnt;
        logic [31:0]       hold_addr;
        logic [LINE_W-1:0] hold_wdata;
        cnt        = 0;
        hold_addr  = '0;
        hold_wdata = '0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (pmem_resp) begin
                pmem_resp = 1'b0;
                cnt       = 0;
            end
            if ((pmem_read || pmem_write) && rst_n) begin
                checks++;
                if (pmem_read && pmem_write) begin
                    errors++;
                    $display("FAIL pmem_exclusive: read=%b write=%b, required not both high", pmem_read, pmem_write);
                end
                if (cnt > 0) begin
                    checks++;
                    if (pmem_address !== hold_addr || (pmem_write && pmem_wdata !== hold_wdata)) begin
                        errors++;
                        $display("FAIL pmem_stable: addr %h, required held %h", pmem_address, hold_addr);
                    end
                end
                hold_addr  = pmem_address;
                hold_wdata = pmem_wdata;
                cnt++;
                if (cnt == LAT) begin
                    if (pmem_write) begin
                        mem_store[pmem_address] = pmem_wdata;
                        log_q.push_back('{wr: 1'b1, addr: pmem_address, data: pmem_wdata});
                    end else begin
                        pmem_rdata = line_of(pmem_address);
                        log_q.push_back('{wr: 1'b0, addr: pmem_address, data: pmem_rdata});
                    end
                    pmem_resp = 1'b1;
                    cnt       = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // One CPU request; cycles counts clock edges from raising the request to seeing mem_resp.
    task automatic cpu_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, output logic [31:0] rdata, output int cycles);
        bit done;
        @(negedge clk);
        mem_read        = !wr;
        mem_write       = wr;
        mem_address     = addr;
        mem_wdata       = wdata;
        mem_byte_enable = be;
        cycles = 0;
        rdata  = '0;
        done   = 1'b0;
        while (!done && cycles < 60) begin
            @(negedge clk);
            cycles++;
            if (mem_resp) begin
                rdata = mem_rdata;
                done  = 1'b1;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL cpu_timeout: addr %h no mem_resp after %0d cycles", addr, cycles);
        end
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_resp !== 1'b0) begin
            errors++;
            $display("FAIL resp_single_pulse: mem_resp=%b after request, required 0", mem_resp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_resp !== 1'b0 || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: resp=%b pread=%b pwrite=%b, required 0 0 0", mem_resp, pmem_read, pmem_write);
        end
        checks++;
        if (pmem_address !== 32'h0) begin
            errors++;
            $display("FAIL reset_paddr: got %h required 00000000", pmem_address);
        end
`ifdef CACHE_NWAY_PERF_CNT_EN
        checks++;
        if (perf_hits !== 32'd0 || perf_misses !== 32'd0 || perf_writebacks !== 32'd0) begin
            errors++;
            $display("FAIL reset_perf: %0d %0d %0d required 0 0 0", perf_hits, perf_misses, perf_writebacks);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_read_miss();
        logic [31:0] rd;
        int          cyc;
        log_q.delete();
        cpu_access(1'b0, 32'h40, 32'h0, 4'h0, rd, cyc);
        checks++;
        if (rd !== 32'h40 || cyc != 2 + LAT) begin
            errors++;
            $display("FAIL miss_read: data %h cycles %0d, required 00000040 %0d", rd, cyc, 2 + LAT);
        end
        checks++;
        if (log_q.size() != 1 || log_q[0].wr || log_q[0].addr !== 32'h40) begin
            errors++;
            $display("FAIL miss_fill_addr: %0d transfers, required one read at 00000040", log_q.size());
        end
        cpu_access(1'b0, 32'h40, 32'h0, 4'h0, rd, cyc);
        checks++;
        if (rd !== 32'h40 || cyc != 1) begin
            errors++;
            $display("FAIL hit_read: data %h cycles %0d, required 00000040 1", rd, cyc);
        end
        cpu_access(1'b0, 32'h5C, 32'h0, 4'h0, rd, cyc);
        checks++;
        if (rd !== 32'h5C || cyc != 1 || log_q.size() != 1) begin
            errors++;
            $display("FAIL hit_last_word: data %h cycles %0d xfers %0d, required 0000005c 1 1", rd, cyc, log_q.size());
        end
    endtask

    task automatic test_write_merge();
        logic [31:0] rd;
        int          cyc;
        log_q.delete();
        cpu_access(1'b1, 32'h44, 32'h1122_3344, 4'hF, rd, cyc);
        checks++;
        if (cyc != 1) begin
            errors++;
            $display("FAIL write_hit_latency: cycles %0d required 1", cyc);
        end
        cpu_access(1'b1, 32'h44, 32'hDEAD_BEEF, 4'b0101, rd, cyc);
        cpu_access(1'b0, 32'h44, 32'h0, 4'h0, rd, cyc);
        checks++;
        if (rd !== 32'h11AD_33EF) begin
            errors++;
            $display("FAIL merge_0101: got %h required 11ad33ef", rd);
        end
        cpu_access(1'b1, 32'h48, 32'h1122_3344, 4'hF, rd, cyc);
        cpu_access(1'b1, 32'h48, 32'hDEAD_BEEF, 4'b0100, rd, cyc);
        cpu_access(1'b0, 32'h48, 32'h0, 4'h0, rd, cyc);
        checks++;
        if (rd !== 32'h11AD_3344) begin
            errors++;
            $display("FAIL merge_0100: got %h required 11ad3344", rd);
        end
        cpu_access(1'b0, 32'h40, 32'h0, 4'h0, rd, cyc);
        checks++;
        if (rd !== 32'h40 || log_q.size() != 0) begin
            errors++;
            $display("FAIL merge_neighbour: got %h xfers %0d, required 00000040 0", rd, log_q.size());
        end
    endtask

    task automatic test_plru_victim();
        logic [31:0] rd;
        int          cyc;
        logic [31:0] order [3];
        for (int i = 0; i < 4; i++) begin
            cpu_access(1'b0, 32'(i * 'h100), 32'h0, 4'h0, rd, cyc);
            checks++;
            if (rd !== 32'(i * 'h100) || cyc != 2 + LAT) begin
                errors++;
                $display("FAIL set0_fill: data %h cycles %0d, required %h %0d", rd, cyc, 32'(i * 'h100), 2 + LAT);
            end
        end
        cpu_access(1'b0, 32'h000, 32'h0, 4'h0, rd, cyc);
        log_q.delete();
        cpu_access(1'b0, 32'h400, 32'h0, 4'h0, rd, cyc);
        checks++;
        if (rd !== 32'h400 || cyc != 2 + LAT || log_q.size() != 1 || log_q[0].wr || log_q[0].addr !== 32'h400) begin
            errors++;
            $display("FAIL plru_clean_miss: data %h cycles %0d xfers %0d, required 00000400 %0d 1", rd, cyc, log_q.size(), 2 + LAT);
        end
        order[0] = 32'h300;
        order[1] = 32'h000;
        order[2] = 32'h200;
        for (int i = 0; i < 3; i++) begin
            cpu_access(1'b0, order[i], 32'h0, 4'h0, rd, cyc);
            checks++;
            if (cyc != 1) begin
                errors++;
                $display("FAIL plru_survivor: addr %h cycles %0d, required 1", order[i], cyc);
            end
        end
        cpu_access(1'b0, 32'h100, 32'h0, 4'h0, rd, cyc);
        checks++;
        if (cyc != 2 + LAT) begin
            errors++;
            $display("FAIL plru_evicted: addr 00000100 cycles %0d, required %0d", cyc, 2 + LAT);
        end
        cpu_access(1'b0, 32'h44, 32'h0, 4'h0, rd, cyc);
        checks++;
        if (rd !== 32'h11AD_33EF || cyc != 1) begin
            errors++;
            $display("FAIL set_independent: data %h cycles %0d, required 11ad33ef 1", rd, cyc);
        end
    endtask

    task automatic test_dirty_writeback();
        logic [31:0]       rd;
        int                cyc;
        logic [LINE_W-1:0] exp_line;
        for (int i = 0; i < 4; i++) cpu_access(1'b0, 32'('h20 + i * 'h100), 32'h0, 4'h0, rd, cyc);
        cpu_access(1'b1, 32'h124, 32'hCAFE_F00D, 4'hF, rd, cyc);
        cpu_access(1'b0, 32'h020, 32'h0, 4'h0, rd, cyc);
        cpu_access(1'b0, 32'h320, 32'h0, 4'h0, rd, cyc);
        cpu_access(1'b0, 32'h220, 32'h0, 4'h0, rd, cyc);
        log_q.delete();
        cpu_access(1'b0, 32'h420, 32'h0, 4'h0, rd, cyc);
        exp_line = default_line(32'h120);
        exp_line[32 +: 32] = 32'hCAFE_F00D;
        checks++;
        if (rd !== 32'h420 || cyc != 2 + 2 * LAT) begin
            errors++;
            $display("FAIL dirty_miss: data %h cycles %0d, required 00000420 %0d", rd, cyc, 2 + 2 * LAT);
        end
        checks++;
        if (log_q.size() != 2 || !log_q[0].wr || log_q[0].addr !== 32'h120 || log_q[0].data !== exp_line) begin
            errors++;
            $display("FAIL wb_first: %0d xfers, first wr=%b addr %h, required write at 00000120 with merged line",
                     log_q.size(), log_q.size() > 0 && log_q[0].wr, log_q.size() > 0 ? log_q[0].addr : 32'h0);
        end
        checks++;
        if (log_q.size() != 2 || log_q[1].wr || log_q[1].addr !== 32'h420) begin
            errors++;
            $display("FAIL fill_after_wb: %0d xfers, required read at 00000420 second", log_q.size());
        end
        cpu_access(1'b0, 32'h124, 32'h0, 4'h0, rd, cyc);
        checks++;
        if (rd !== 32'hCAFE_F00D || cyc != 2 + LAT) begin
            errors++;
            $display("FAIL wb_data_refill: data %h cycles %0d, required cafef00d %0d", rd, cyc, 2 + LAT);
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] rd;
        int          cyc;
        int          n;
        @(negedge clk);
        mem_read    = 1'b1;
        mem_write   = 1'b0;
        mem_address = 32'h600;
        n = 0;
        while (!pmem_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (pmem_read !== 1'b1) begin
            errors++;
            $display("FAIL fill_start: pmem_read=%b after %0d cycles, required 1", pmem_read, n);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (pmem_read !== 1'b0 || pmem_address !== 32'h0) begin
            errors++;
            $display("FAIL reset_abort: pmem_read=%b addr %h, required 0 00000000", pmem_read, pmem_address);
        end
        mem_read = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        log_q.delete();
        cpu_access(1'b0, 32'h600, 32'h0, 4'h0, rd, cyc);
        checks++;
        if (rd !== 32'h600 || cyc != 2 + LAT || log_q.size() != 1 || log_q[0].addr !== 32'h600) begin
            errors++;
            $display("FAIL refetch_after_reset: data %h cycles %0d xfers %0d, required 00000600 %0d 1",
                     rd, cyc, log_q.size(), 2 + LAT);
        end
    endtask

`ifdef CACHE_NWAY_PERF_CNT_EN
    task automatic test_perf_counters();
        logic [31:0] rd;
        int          cyc;
        logic [31:0] h0, m0, w0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cpu_access(1'b0, 32'(i * 'h100), 32'h0, 4'h0, rd, cyc);
        cpu_access(1'b1, 32'h100, 32'h5555_AAAA, 4'hF, rd, cyc);
        h0 = perf_hits;
        m0 = perf_misses;
        w0 = perf_writebacks;
        cpu_access(1'b0, 32'h400, 32'h0, 4'h0, rd, cyc);
        cpu_access(1'b0, 32'h300, 32'h0, 4'h0, rd, cyc);
        cpu_access(1'b0, 32'h400, 32'h0, 4'h0, rd, cyc);
        cpu_access(1'b0, 32'h500, 32'h0, 4'h0, rd, cyc);
        checks++;
        if (cyc != 2 + 2 * LAT) begin
            errors++;
            $display("FAIL perf_dirty_miss: cycles %0d required %0d", cyc, 2 + 2 * LAT);
        end
        checks++;
        if (perf_hits - h0 !== 32'd2) begin
            errors++;
            $display("FAIL perf_hits: delta %0d required 2", perf_hits - h0);
        end
        checks++;
        if (perf_misses - m0 !== 32'd2) begin
            errors++;
            $display("FAIL perf_misses: delta %0d required 2", perf_misses - m0);
        end
        checks++;
        if (perf_writebacks - w0 !== 32'd1) begin
            errors++;
            $display("FAIL perf_writebacks: delta %0d required 1", perf_writebacks - w0);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks          = 0;
        errors          = 0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = 32'h0;
        mem_wdata       = 32'h0;
        mem_byte_enable = 4'h0;
        test_reset();
        test_read_miss();
        test_write_merge();
        test_plru_victim();
        test_dirty_writeback();
        test_reset_mid_fill();
`ifdef CACHE_NWAY_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
